alu_arbiter: RTL and testbench

- Shares one combinational ALU instance between two requesters (port 0, port 1), e.g. a core's execute stage and a debug/DMA address-calc unit.
- Per cycle, grants at most one request using round-robin arbitration and drives the shared ALU's SrcA/SrcB/ALUControl.
- Captures ALUResult/Zero into the granted port's response register.
- Per-port valid/ready handshakes on request and response sides; one-cycle issue-to-response latency.

---
 rtl/alu_arbiter_if.sv | 26 ++
 rtl/alu_arbiter.sv | 106 ++++++++++
 tb/tb_alu_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// One requester's view of the shared ALU arbiter.
// Request operands and handshake go in; the captured result and its handshake come back.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [CTRLW-1:0] ALUControl;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;

  modport master (
    output req_valid, SrcA, SrcB, ALUControl, rsp_ready,
    input  req_ready, rsp_valid, Result, Zero
  );

  modport slave (
    input  req_valid, SrcA, SrcB, ALUControl, rsp_ready,
    output req_ready, rsp_valid, Result, Zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// with a one-entry response register per port.
//
// state | meaning
// EMPTY | response register holds nothing, rsp_valid low
// FULL  | response register holds a result awaiting rsp_ready
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 3
) (
  input  logic             clk,
  input  logic             reset,
  alu_arbiter_if.slave     p0,
  alu_arbiter_if.slave     p1,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [CTRLW-1:0] ALUControl,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             Zero,
  output logic             last_grant
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t            slot0_q, slot0_d, slot1_q, slot1_d;
  logic             free0, free1, elig0, elig1;
  logic             grant0, grant1;
  logic [WIDTH-1:0] result0_q, result1_q;
  logic             zero0_q, zero1_q;
  logic             last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q   <= EMPTY;
      slot1_q   <= EMPTY;
      result0_q <= '0;
      result1_q <= '0;
      zero0_q   <= 1'b0;
      zero1_q   <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      if (grant0) begin
        result0_q <= ALUResult;
        zero0_q   <= Zero;
        last_q    <= 1'b0;
      end
      if (grant1) begin
        result1_q <= ALUResult;
        zero1_q   <= Zero;
        last_q    <= 1'b1;
      end
    end
  end

  always_comb begin
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    grant0     = 1'b0;
    grant1     = 1'b0;
    SrcA       = '0;
    SrcB       = '0;
    ALUControl = '0;

    // A slot draining this cycle can be refilled in the same cycle.
    free0 = (slot0_q == EMPTY) || p0.rsp_ready;
    free1 = (slot1_q == EMPTY) || p1.rsp_ready;
    elig0 = p0.req_valid && free0;
    elig1 = p1.req_valid && free1;

    if (elig0 && elig1) begin
      grant0 = last_q;
      grant1 = !last_q;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end

    if (grant0) begin
      SrcA       = p0.SrcA;
      SrcB       = p0.SrcB;
      ALUControl = p0.ALUControl;
    end else if (grant1) begin
      SrcA       = p1.SrcA;
      SrcB       = p1.SrcB;
      ALUControl = p1.ALUControl;
    end

    if (grant0)                                slot0_d = FULL;
    else if (slot0_q == FULL && p0.rsp_ready) slot0_d = EMPTY;
    if (grant1)                                slot1_d = FULL;
    else if (slot1_q == FULL && p1.rsp_ready) slot1_d = EMPTY;
  end

  assign p0.req_ready = grant0;
  assign p1.req_ready = grant1;
  assign p0.rsp_valid = (slot0_q == FULL);
  assign p1.rsp_valid = (slot1_q == FULL);
  assign p0.Result    = result0_q;
  assign p1.Result    = result1_q;
  assign p0.Zero      = zero0_q;
  assign p1.Zero      = zero1_q;
  assign last_grant   = last_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter; a simple ALU model sits on the
// shared-ALU side and a per-port slot model predicts every output each cycle.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int CTRLW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH), .CTRLW(CTRLW)) i0 ();
  alu_arbiter_if #(.WIDTH(WIDTH), .CTRLW(CTRLW)) i1 ();

  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [CTRLW-1:0] alu_c;
  logic             alu_zero, last_grant;

  alu_arbiter #(.WIDTH(WIDTH), .CTRLW(CTRLW)) dut (
    .clk(clk), .reset(rst), .p0(i0), .p1(i1),
    .SrcA(alu_a), .SrcB(alu_b), .ALUControl(alu_c),
    .ALUResult(alu_res), .Zero(alu_zero), .last_grant(last_grant)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b110:  return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  assign alu_res  = alu_fn(alu_a, alu_b, alu_c);
  assign alu_zero = (alu_res == '0);

  // requester-side stimulus, index = port
  logic        rv[2], rr[2];
  logic [31:0] ra[2], rb[2];
  logic [2:0]  rc[2];
  assign i0.req_valid = rv[0]; assign i0.rsp_ready = rr[0];
  assign i0.SrcA = ra[0]; assign i0.SrcB = rb[0]; assign i0.ALUControl = rc[0];
  assign i1.req_valid = rv[1]; assign i1.rsp_ready = rr[1];
  assign i1.SrcA = ra[1]; assign i1.SrcB = rb[1]; assign i1.ALUControl = rc[1];

  // reference model: what each requester should currently see
  logic        m_valid[2], m_zero[2];
  logic [31:0] m_res[2];
  logic        m_last;
  logic        seen_rdy[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_res[i] = '0; m_zero[i] = 1'b0;
    end
    m_last = 1'b1;
  endtask

  // One clock: predict and check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int          g;
    logic [31:0] ea, eb, er;
    logic [2:0]  ec;
    logic        elig[2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) elig[i] = rv[i] && (!m_valid[i] || rr[i]);
    if (elig[0] && elig[1]) g = m_last ? 0 : 1;
    else if (elig[0])       g = 0;
    else if (elig[1])       g = 1;
    else                    g = -1;
    ea = (g >= 0) ? ra[g] : 32'd0;
    eb = (g >= 0) ? rb[g] : 32'd0;
    ec = (g >= 0) ? rc[g] : 3'd0;
    er = alu_fn(ea, eb, ec);
    seen_rdy[0] = i0.req_ready;
    seen_rdy[1] = i1.req_ready;
    chk("req0_ready", {31'd0, i0.req_ready}, {31'd0, g == 0});
    chk("req1_ready", {31'd0, i1.req_ready}, {31'd0, g == 1});
    chk("SrcA", alu_a, ea);
    chk("SrcB", alu_b, eb);
    chk("ALUControl", {29'd0, alu_c}, {29'd0, ec});
    chk("last_grant", {31'd0, last_grant}, {31'd0, m_last});
    chk("rsp0_valid", {31'd0, i0.rsp_valid}, {31'd0, m_valid[0]});
    chk("rsp1_valid", {31'd0, i1.rsp_valid}, {31'd0, m_valid[1]});
    chk("rsp0_Result", i0.Result, m_res[0]);
    chk("rsp1_Result", i1.Result, m_res[1]);
    chk("rsp0_Zero", {31'd0, i0.Zero}, {31'd0, m_zero[0]});
    chk("rsp1_Zero", {31'd0, i1.Zero}, {31'd0, m_zero[1]});
    @(posedge clk);
    if (rst) model_reset();
    else begin
      for (int i = 0; i < 2; i++) begin
        if (g == i) begin
          m_valid[i] = 1'b1; m_res[i] = er; m_zero[i] = (er == 32'd0);
        end else if (m_valid[i] && rr[i]) m_valid[i] = 1'b0;
      end
      if (g >= 0) m_last = (g == 1);
    end
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] c);
    rv[p] = v; ra[p] = a; rb[p] = b; rc[p] = c;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic prev0;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, 32'd0, 32'd0, 3'd0);
      rr[i] = 1'b1;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset, then idle
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    chk("idle_last_grant", {31'd0, last_grant}, 32'd1);
    chk("idle_rsp0_valid", {31'd0, i0.rsp_valid}, 32'd0);

    // single ADD on port 0
    set_req(0, 1'b1, 32'd5, 32'd7, 3'b000);
    cycle();
    chk("single_ready", {31'd0, seen_rdy[0]}, 32'd1);
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    chk("single_result", i0.Result, 32'd12);
    chk("single_valid", {31'd0, i0.rsp_valid}, 32'd1);
    chk("single_zero", {31'd0, i0.Zero}, 32'd0);

    // contention: port 0 won last, so port 1 goes first, then strict alternation
    set_req(0, 1'b1, 32'd9, 32'd9, 3'b001);
    set_req(1, 1'b1, 32'd3, 32'd8, 3'b101);
    cycle();
    chk("cont_first", {31'd0, seen_rdy[1]}, 32'd1);
    prev0 = seen_rdy[0];
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("cont_alt", {31'd0, seen_rdy[0]}, {31'd0, ~prev0});
      prev0 = seen_rdy[0];
    end
    chk("cont_res0", i0.Result, 32'd0);
    chk("cont_zero0", {31'd0, i0.Zero}, 32'd1);
    chk("cont_res1", i1.Result, 32'd1);
    chk("cont_zero1", {31'd0, i1.Zero}, 32'd0);

    // backpressure on port 1
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    cycle();
    set_req(1, 1'b1, 32'd1, 32'd4, 3'b110);
    rr[1] = 1'b0;
    repeat (2) begin
      cycle();
      chk("bp_stall", {31'd0, seen_rdy[1]}, 32'd0);
      chk("bp_hold", i1.Result, 32'd1);
    end
    rr[1] = 1'b1;
    cycle();
    chk("bp_release", {31'd0, seen_rdy[1]}, 32'd1);
    chk("bp_result", i1.Result, 32'd16);
    set_req(1, 1'b0, 32'd0, 32'd0, 3'd0);

    // back-to-back on port 0
    set_req(0, 1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b100);
    cycle();
    chk("b2b_rdy_a", {31'd0, seen_rdy[0]}, 32'd1);
    chk("b2b_res_a", i0.Result, 32'h0000_00FF);
    set_req(0, 1'b1, 32'h0000_0100, 32'h0000_0001, 3'b011);
    cycle();
    chk("b2b_rdy_b", {31'd0, seen_rdy[0]}, 32'd1);
    chk("b2b_res_b", i0.Result, 32'h0000_0101);

    // reset while port 0 holds a result and port 1 is being granted
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    rr[0] = 1'b0;
    set_req(1, 1'b1, 32'd2, 32'd3, 3'b000);
    rst = 1'b1;
    cycle();
    chk("rst_mid_grant", {31'd0, seen_rdy[1]}, 32'd1);
    chk("rst_mid_v0", {31'd0, i0.rsp_valid}, 32'd0);
    chk("rst_mid_v1", {31'd0, i1.rsp_valid}, 32'd0);
    chk("rst_mid_last", {31'd0, last_grant}, 32'd1);
    rst = 1'b0;
    rr[0] = 1'b1;
    set_req(0, 1'b1, 32'd4, 32'd4, 3'b001);
    cycle();
    chk("rst_prio0", {31'd0, seen_rdy[0]}, 32'd1);
    chk("rst_prio1", {31'd0, seen_rdy[1]}, 32'd0);

    // randomized traffic; requesters hold a request until it is accepted
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rv[p] || seen_rdy[p]) begin
          ra[p] = $urandom();
          rb[p] = ($urandom_range(0, 3) == 0) ? ra[p] : $urandom();
          rc[p] = 3'($urandom_range(0, 7));
          rv[p] = ($urandom_range(0, 3) != 0);
        end
        rr[p] = ($urandom_range(0, 2) != 0);
      end
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
